// File: rtl/lane_gene_collector_pkg.sv
// Shared defaults and state encoding for the lane gene collector.
// Imported by the collector top and its FIFO.
package lane_gene_collector_pkg;

  localparam int GENE_SZ_DEF    = 64;
  localparam int ATTR_SZ_DEF    = 8;
  localparam int ADDR_SZ_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_GENES_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } col_state_t;

  function automatic logic is_active(input col_state_t s);
    return (s == COLLECT) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/lane_gene_collector_gene_fifo.sv
// gene_fifo: synchronous FIFO buffering lane genes ahead of the memory port.
// Ports: clk, rst (sync active-low), push/din, pop/head, full, empty.
module gene_fifo
  import lane_gene_collector_pkg::*;
#(
  parameter int GENE_SZ    = GENE_SZ_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [GENE_SZ-1:0] din,
  input  logic               pop,
  output logic [GENE_SZ-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [GENE_SZ-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;
  logic               do_pop;
  logic               do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push while full is legal only when a pop frees the slot on this edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{PW{1'b0}}, do_push}
             - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lane_gene_collector.sv
// lane_gene_collector: buffers lane genes and writes them to genome memory.
// Ports: start/base_addr, gene_in/in_valid/src_done, mem_* write port,
//        busy/done/gene_count/overflow status.
module lane_gene_collector
  import lane_gene_collector_pkg::*;
#(
  parameter int GENE_SZ    = GENE_SZ_DEF,
  parameter int ATTR_SZ    = ATTR_SZ_DEF,
  parameter int ADDR_SZ    = ADDR_SZ_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_GENES  = MAX_GENES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_SZ-1:0] base_addr,
  input  logic [GENE_SZ-1:0] gene_in,
  input  logic               in_valid,
  input  logic               src_done,
  output logic               mem_we,
  output logic [ADDR_SZ-1:0] mem_addr,
  output logic [GENE_SZ-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_SZ:0]   gene_count,
  output logic               overflow
);

  localparam int CW = ADDR_SZ + 1;
  localparam int AW = $clog2(MAX_GENES + 1);

  if (ATTR_SZ < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("lane_gene_collector: bad parameters");
  end

  col_state_t         state;
  col_state_t         state_nxt;
  logic [ADDR_SZ-1:0] base;
  logic [AW-1:0]      accepted;

  logic               f_push;
  logic               f_pop;
  logic               f_full;
  logic               f_empty;
  logic [GENE_SZ-1:0] f_head;

  logic               active;
  logic               retire;
  logic               push_req;
  logic               room;
  logic               drop;
  logic [CW-1:0]      cnt_nxt;

  assign active   = is_active(state);
  assign retire   = mem_we && mem_ready;
  // Refill the write register when it is free or retiring this edge.
  assign f_pop    = active && !f_empty && (!mem_we || retire);
  assign push_req = (state == COLLECT) && in_valid;
  assign room     = (accepted < AW'(MAX_GENES));
  assign f_push   = push_req && room && (!f_full || f_pop);
  assign drop     = push_req && !f_push;
  assign cnt_nxt  = gene_count + CW'(retire);

  assign busy = active;
  assign done = (state == DONE);

  gene_fifo #(
    .GENE_SZ    (GENE_SZ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .din   (gene_in),
    .pop   (f_pop),
    .head  (f_head),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = COLLECT;
      COLLECT: if (src_done) state_nxt = DRAIN;
      DRAIN: begin
        if (f_empty && (!mem_we || retire))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base       <= '0;
      accepted   <= '0;
      gene_count <= '0;
      overflow   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (state == IDLE && start) begin
        base       <= base_addr;
        gene_count <= '0;
        accepted   <= '0;
        overflow   <= 1'b0;
      end
      if (retire) gene_count <= cnt_nxt;
      if (f_pop) begin
        mem_we    <= 1'b1;
        mem_wdata <= f_head;
        mem_addr  <= base + cnt_nxt[ADDR_SZ-1:0];
      end else if (retire) begin
        mem_we <= 1'b0;
      end
      if (f_push) accepted <= accepted + 1'b1;
      if (drop)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_gene_collector.sv
// Scoreboard bench for lane_gene_collector: expected writes are queued
// as genes are driven and matched against retiring memory writes.
module tb_lane_gene_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [63:0] gene_in;
  logic        in_valid;
  logic        src_done;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [8:0]  gene_count;
  logic        overflow;

  lane_gene_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .gene_in    (gene_in),
    .in_valid   (in_valid),
    .src_done   (src_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .gene_count (gene_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  logic [71:0] sbq[$];
  int          wcyc[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  int          n_done = 0;
  int          cyc   = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [71:0] e;
    cyc++;
    if (rst && done) n_done++;
    if (rst && mem_we && mem_ready) begin
      n_wr++;
      wcyc.push_back(cyc);
      if (sbq.size() == 0) begin
        check("sb_underrun", 64'(sbq.size()), 64'd1);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[71:64]));
        check("wr_data", mem_wdata, e[63:0]);
      end
    end
  end

  function automatic logic [63:0] gv(input int i);
    return {32'hC0DE_0000 + 32'(i), ~32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [63:0] g, input logic [7:0] b,
                      input int idx, input bit keep);
    gene_in  = g;
    in_valid = 1'b1;
    if (keep) sbq.push_back({b + 8'(idx), g});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_src();
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int k;
    bit seen;
    d0   = n_done;
    seen = 1'b0;
    for (k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(n_done - d0), 64'd1);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b0; start = 1'b0; base_addr = '0; gene_in = '0;
    in_valid = 1'b0; src_done = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_we",    64'(mem_we),     64'd0);
    check("rst_addr",  64'(mem_addr),   64'd0);
    check("rst_wdata", mem_wdata,       64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_done",  64'(done),       64'd0);
    check("rst_cnt",   64'(gene_count), 64'd0);
    check("rst_ovf",   64'(overflow),   64'd0);
    rst = 1'b1;
    tick();

    // basic stream with latency check
    mem_ready = 1'b1;
    do_start(8'h10);
    check("busy_after_start", 64'(busy), 64'd1);
    wcyc.delete();
    gene_in = gv(1); in_valid = 1'b1; sbq.push_back({8'h10, gv(1)});
    tick();
    gene_in = gv(2); sbq.push_back({8'h11, gv(2)});
    @(negedge clk);
    check("lat_we_n", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    gene_in = gv(3); sbq.push_back({8'h12, gv(3)});
    @(negedge clk);
    check("lat_we_n1", 64'(mem_we), 64'd1);
    check("lat_data",  mem_wdata,   gv(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_src();
    wait_done();
    check("basic_cnt", 64'(gene_count), 64'd3);
    check("basic_ovf", 64'(overflow),   64'd0);
    check("basic_nwr", 64'(wcyc.size()), 64'd3);
    if (wcyc.size() == 3)
      check("basic_b2b", 64'(wcyc[2] - wcyc[0]), 64'd2);

    // stall: FIFO plus write register hold 5, sixth is dropped
    mem_ready = 1'b0;
    do_start(8'h20);
    for (int i = 0; i < 6; i++) send(gv(16 + i), 8'h20, i, i < 5);
    @(negedge clk);
    check("stall_ovf_early", 64'(overflow), 64'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    finish_src();
    wait_done();
    check("stall_cnt", 64'(gene_count), 64'd5);
    check("stall_ovf", 64'(overflow),   64'd1);

    // full with simultaneous pop: no drop
    mem_ready = 1'b0;
    do_start(8'h30);
    for (int i = 0; i < 5; i++) send(gv(32 + i), 8'h30, i, 1'b1);
    mem_ready = 1'b1;
    send(gv(37), 8'h30, 5, 1'b1);
    finish_src();
    wait_done();
    check("fullpop_cnt", 64'(gene_count), 64'd6);
    check("fullpop_ovf", 64'(overflow),   64'd0);

    // address wrap
    mem_ready = 1'b1;
    do_start(8'hFE);
    for (int i = 0; i < 4; i++) send(gv(48 + i), 8'hFE, i, 1'b1);
    finish_src();
    wait_done();
    check("wrap_cnt", 64'(gene_count), 64'd4);

    // empty genome; in_valid during DRAIN is ignored
    w0 = n_wr;
    do_start(8'h50);
    finish_src();
    gene_in = gv(99); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done();
    check("empty_cnt", 64'(gene_count), 64'd0);
    check("empty_nwr", 64'(n_wr - w0),  64'd0);
    check("empty_ovf", 64'(overflow),   64'd0);

    // reset during DRAIN with an outstanding write
    mem_ready = 1'b0;
    do_start(8'h60);
    send(gv(64), 8'h60, 0, 1'b1);
    send(gv(65), 8'h60, 1, 1'b1);
    finish_src();
    @(negedge clk);
    check("pre_rst_we",   64'(mem_we), 64'd1);
    check("pre_rst_busy", 64'(busy),   64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("mid_rst_we",    64'(mem_we),     64'd0);
    check("mid_rst_addr",  64'(mem_addr),   64'd0);
    check("mid_rst_wdata", mem_wdata,       64'd0);
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_cnt",   64'(gene_count), 64'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    do_start(8'h70);
    send(gv(80), 8'h70, 0, 1'b1);
    send(gv(81), 8'h70, 1, 1'b1);
    finish_src();
    wait_done();
    check("post_rst_cnt", 64'(gene_count), 64'd2);
    check("post_rst_ovf", 64'(overflow),   64'd0);

    // MAX_GENES limit
    do_start(8'h00);
    for (int i = 0; i < 258; i++) send(gv(256 + i), 8'h00, i, i < 256);
    finish_src();
    wait_done();
    check("max_cnt", 64'(gene_count), 64'd256);
    check("max_ovf", 64'(overflow),   64'd1);

    check("sb_left", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
